// File: rtl/timebase_pkg.sv
// ============================================================================
// timebase_pkg : shared state and mode encodings for the programmable time base
// Revision 1.0
// ============================================================================
`default_nettype none

package timebase_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

endpackage

`default_nettype wire

// File: rtl/timebase_if.sv
// ============================================================================
// timebase_if : control/status bundle between a sequencer and timebase_prog
// Revision 1.0
// ============================================================================
`default_nettype none

interface timebase_if #(
   parameter int WIDTH     = 8,
   parameter int PRE_WIDTH = 8
);
   logic                 start;
   logic                 stop;
   logic                 hold;
   logic                 mode;
   logic [WIDTH-1:0]     period;
   logic [PRE_WIDTH-1:0] prescale;
   logic [WIDTH-1:0]     count;
   logic                 busy;
   logic                 eot;

   modport master (
      output start, stop, hold, mode, period, prescale,
      input  count, busy, eot
   );

   modport slave (
      input  start, stop, hold, mode, period, prescale,
      output count, busy, eot
   );
endinterface

`default_nettype wire

// File: rtl/timebase_prescaler.sv
// ============================================================================
// timebase_prescaler : strobes once every p+1 enabled clocks
// Revision 1.0
// ============================================================================
`default_nettype none

module timebase_prescaler #(
   parameter int PRE_WIDTH = 8
) (
   input  wire logic                 clk,
   input  wire logic                 rst,
   input  wire logic                 clr,
   input  wire logic                 en,
   input  wire logic [PRE_WIDTH-1:0] p,
   output logic                      strobe
);

   logic [PRE_WIDTH-1:0] r_pc;

   assign strobe = en && (r_pc == p);

   // Disabled cycles leave r_pc untouched, which is what makes hold a pure delay.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc <= '0;
      end else if (clr || strobe) begin
         r_pc <= '0;
      end else if (en) begin
         r_pc <= r_pc + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/timebase_prog.sv
// ============================================================================
// timebase_prog : programmable one-shot/periodic time base with eot pulse
// Optional prescaler enabled by TIMEBASE_PRESCALER_EN.   Revision 1.0
// ============================================================================
`default_nettype none

module timebase_prog
   import timebase_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int PRE_WIDTH = 8
) (
   input wire logic  clk,
   input wire logic  rst,
   timebase_if.slave bus
);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_next;
   logic [WIDTH-1:0] r_period;
   logic             r_mode;
   logic             r_eot;
   logic             w_eot_next;
   logic             w_load;
   logic             w_step_en;
   logic             w_strobe;

   assign w_step_en = (r_state == RUN) && !bus.hold;

`ifdef TIMEBASE_PRESCALER_EN
   logic [PRE_WIDTH-1:0] r_prescale;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prescale <= '0;
      end else if (w_load) begin
         r_prescale <= bus.prescale;
      end
   end

   timebase_prescaler #(
      .PRE_WIDTH (PRE_WIDTH)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .clr    (w_load),
      .en     (w_step_en),
      .p      (r_prescale),
      .strobe (w_strobe)
   );
`else
   logic unused_prescale;

   assign unused_prescale = ^bus.prescale;
   assign w_strobe        = w_step_en;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_period <= '0;
         r_mode   <= MODE_ONESHOT;
      end else if (w_load) begin
         r_period <= bus.period;
         r_mode   <= bus.mode;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_count <= '0;
         r_eot   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
         r_eot   <= w_eot_next;
      end
   end

   // stop outranks a coincident terminal strobe, so an aborted run never pulses eot.
   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      w_eot_next   = 1'b0;
      w_load       = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_count_next = '0;
            if (bus.start && !bus.stop) begin
               w_load       = 1'b1;
               w_state_next = RUN;
            end
         end
         RUN: begin
            if (bus.stop) begin
               w_state_next = IDLE;
               w_count_next = '0;
            end else if (w_strobe) begin
               if (r_count == r_period) begin
                  w_count_next = '0;
                  w_eot_next   = 1'b1;
                  if (r_mode == MODE_ONESHOT) begin
                     w_state_next = IDLE;
                  end
               end else begin
                  w_count_next = r_count + 1'b1;
               end
            end
         end
         default: begin
            w_state_next = IDLE;
            w_count_next = '0;
         end
      endcase
   end

   assign bus.count = r_count;
   assign bus.busy  = (r_state == RUN);
   assign bus.eot   = r_eot;

endmodule

`default_nettype wire
